// File: rtl/vreg_stream_file.sv
// Vector register file. Low addresses map to per-stream push FIFOs, the rest to lane-writable storage.
// Define VREG_BYPASS_EN for write-first same-cycle reads. Without it, reads return the pre-write contents.
module vreg_stream_file #(
   parameter int WIDTH_ADDR  = 4,
   parameter int LANES       = 8,
   parameter int N           = 32,
   parameter int NUM_RD      = 2,
   parameter int NUM_STREAMS = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                                      clk,
   input  logic                                      rstn,
   input  logic                                      rd_en,
   input  logic [NUM_RD-1:0][WIDTH_ADDR-1:0]         rd_addr,
   output logic [NUM_RD-1:0][LANES-1:0][N-1:0]       rd_data,
   output logic                                      rd_valid,
   output logic                                      stall,
   input  logic [LANES-1:0]                          wr_lane_en,
   input  logic [WIDTH_ADDR-1:0]                     wr_addr,
   input  logic [LANES-1:0][N-1:0]                   wr_data,
   input  logic [NUM_STREAMS-1:0]                    s_valid,
   output logic [NUM_STREAMS-1:0]                    s_ready,
   input  logic [NUM_STREAMS-1:0][LANES-1:0][N-1:0]  s_data
);
   localparam int ENTRIES = 1 << WIDTH_ADDR;
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   typedef logic [LANES-1:0][N-1:0] entry_t;

   entry_t                      mem [ENTRIES];
   entry_t [NUM_STREAMS-1:0]    head;
   entry_t [NUM_RD-1:0]         sel;
   logic   [NUM_STREAMS-1:0]    empty;
   logic   [NUM_STREAMS-1:0]    ref_s;
   logic   [NUM_STREAMS-1:0]    pop;
   logic                        wr_reg;
   logic                        accept;
   logic   [1:0]                vld_pipe;

   // Stream-mapped addresses have no backing storage, so writes there vanish.
   assign wr_reg = (wr_addr >= WIDTH_ADDR'(NUM_STREAMS));

   always_ff @(posedge clk)
      if (wr_reg)
         for (int i = 0; i < LANES; i++)
            if (wr_lane_en[i]) mem[wr_addr][i] <= wr_data[i];

   for (genvar k = 0; k < NUM_STREAMS; k++) begin : g_fifo
      entry_t      arr [FIFO_DEPTH];
      logic [AW:0] wptr, rptr;
      logic        push;

      assign empty[k]   = (wptr == rptr);
      assign s_ready[k] = !((wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]));
      assign push       = s_valid[k] & s_ready[k];
      // Head comes from storage only, so a fresh push is poppable one cycle later.
      assign head[k]    = arr[rptr[AW-1:0]];

      always_ff @(posedge clk or negedge rstn)
         if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
         end else begin
            if (push)   wptr <= wptr + PTR_ONE;
            if (pop[k]) rptr <= rptr + PTR_ONE;
         end

      always_ff @(posedge clk)
         if (push) arr[wptr[AW-1:0]] <= s_data[k];
   end

   always_comb begin
      ref_s = '0;
      sel   = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         sel[p] = mem[rd_addr[p]];
         for (int k = 0; k < NUM_STREAMS; k++)
            if (rd_addr[p] == WIDTH_ADDR'(k)) begin
               sel[p]   = head[k];
               ref_s[k] = 1'b1;
            end
`ifdef VREG_BYPASS_EN
         if (wr_reg && (rd_addr[p] == wr_addr))
            for (int i = 0; i < LANES; i++)
               if (wr_lane_en[i]) sel[p][i] = wr_data[i];
`endif
      end
   end

   // Issue is all-or-nothing: one empty referenced stream blocks every pop.
   assign stall       = rd_en & |(ref_s & empty);
   assign accept      = rd_en & ~stall;
   assign pop         = ref_s & {NUM_STREAMS{accept}};
   assign vld_pipe[0] = accept;
   assign rd_valid    = vld_pipe[1];

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         vld_pipe[1] <= 1'b0;
         rd_data     <= '0;
      end else begin
         vld_pipe[1] <= vld_pipe[0];
         if (accept) rd_data <= sel;
      end
endmodule

// File: tb/tb_vreg_stream_file.sv
// Directed bench for vreg_stream_file: register vector table plus stream, stall, full and reset sequences.
module tb_vreg_stream_file;
   localparam int WA = 4, LANES = 8, N = 32, NUM_RD = 2, NS = 2, FD = 4;

   logic                                 clk = 1'b0;
   logic                                 rstn;
   logic                                 rd_en;
   logic [NUM_RD-1:0][WA-1:0]            rd_addr;
   logic [NUM_RD-1:0][LANES-1:0][N-1:0]  rd_data;
   logic                                 rd_valid;
   logic                                 stall;
   logic [LANES-1:0]                     wr_lane_en;
   logic [WA-1:0]                        wr_addr;
   logic [LANES-1:0][N-1:0]              wr_data;
   logic [NS-1:0]                        s_valid;
   logic [NS-1:0]                        s_ready;
   logic [NS-1:0][LANES-1:0][N-1:0]      s_data;

   int n_chk = 0, n_pass = 0;

   vreg_stream_file #(.WIDTH_ADDR(WA), .LANES(LANES), .N(N), .NUM_RD(NUM_RD),
                      .NUM_STREAMS(NS), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rstn(rstn), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_valid(rd_valid), .stall(stall), .wr_lane_en(wr_lane_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data));

   always #5 clk = ~clk;

   typedef struct {
      logic [WA-1:0]    wa;
      logic [LANES-1:0] wen;
      logic [N-1:0]     wv;
      logic [WA-1:0]    ra0, ra1;
      logic [255:0]     e0, e1;
   } vec_t;

   vec_t tbl [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", nm, got, exp);
   endtask

   task automatic push(input int k, input logic [N-1:0] v);
      s_valid[k] = 1'b1;
      s_data[k]  = {LANES{v}};
      tick();
      s_valid[k] = 1'b0;
   endtask

   task automatic issue(input logic [WA-1:0] a0, input logic [WA-1:0] a1);
      rd_addr[0] = a0;
      rd_addr[1] = a1;
      rd_en      = 1'b1;
      tick();
      rd_en      = 1'b0;
   endtask

   // Probe stall without crossing a clock edge.
   task automatic probe_stall(input string nm, input logic [WA-1:0] a0, input logic [WA-1:0] a1,
                              input logic exp);
      rd_addr[0] = a0;
      rd_addr[1] = a1;
      rd_en      = 1'b1;
      #1;
      chk(nm, 256'(stall), 256'(exp));
      rd_en      = 1'b0;
   endtask

   initial begin
      tbl[0] = '{4'd5,  8'hFF, 32'hA5A5A5A5, 4'd5,  4'd5,  {8{32'hA5A5A5A5}}, {8{32'hA5A5A5A5}}};
      tbl[1] = '{4'd6,  8'hFF, 32'h11111111, 4'd6,  4'd5,  {8{32'h11111111}}, {8{32'hA5A5A5A5}}};
      tbl[2] = '{4'd6,  8'hF0, 32'h22222222, 4'd5,  4'd6,  {8{32'hA5A5A5A5}},
                 {{4{32'h22222222}}, {4{32'h11111111}}}};
      tbl[3] = '{4'd15, 8'hFF, 32'h12345678, 4'd15, 4'd15, {8{32'h12345678}}, {8{32'h12345678}}};
      tbl[4] = '{4'd15, 8'h01, 32'hCAFEF00D, 4'd6,  4'd15,
                 {{4{32'h22222222}}, {4{32'h11111111}}}, {{7{32'h12345678}}, 32'hCAFEF00D}};
      tbl[5] = '{4'd2,  8'hFF, 32'hDEADBEEF, 4'd2,  4'd15, {8{32'hDEADBEEF}},
                 {{7{32'h12345678}}, 32'hCAFEF00D}};
      tbl[6] = '{4'd0,  8'hFF, 32'h99999999, 4'd2,  4'd2,  {8{32'hDEADBEEF}}, {8{32'hDEADBEEF}}};

      rstn = 1'b0; rd_en = 1'b0; rd_addr = '0; wr_lane_en = '0; wr_addr = '0; wr_data = '0;
      s_valid = '0; s_data = '0;
      tick(); tick();
      chk("rst_rd_valid", 256'(rd_valid), 256'(0));
      chk("rst_rd_data0", rd_data[0], '0);
      chk("rst_rd_data1", rd_data[1], '0);
      chk("rst_s_ready", 256'(s_ready), 256'(2'b11));
      rstn = 1'b1;
      tick();

      // Register write then read-back vectors.
      for (int i = 0; i < 7; i++) begin
         wr_addr = tbl[i].wa; wr_lane_en = tbl[i].wen; wr_data = {LANES{tbl[i].wv}};
         tick();
         wr_lane_en = '0;
         issue(tbl[i].ra0, tbl[i].ra1);
         chk($sformatf("vec%0d_valid", i), 256'(rd_valid), 256'(1));
         chk($sformatf("vec%0d_port0", i), rd_data[0], tbl[i].e0);
         chk($sformatf("vec%0d_port1", i), rd_data[1], tbl[i].e1);
      end
      tick();
      chk("idle_valid_low", 256'(rd_valid), 256'(0));
      chk("idle_data_hold", rd_data[1], {8{32'hDEADBEEF}});

      // Stream 0 shared by both ports: one pop per issue.
      push(0, 32'd1);
      push(0, 32'd2);
      issue(4'd0, 4'd0);
      chk("s0_first_p0", rd_data[0], {8{32'd1}});
      chk("s0_first_p1", rd_data[1], {8{32'd1}});
      issue(4'd0, 4'd0);
      chk("s0_second_p0", rd_data[0], {8{32'd2}});
      chk("s0_second_p1", rd_data[1], {8{32'd2}});
      probe_stall("s0_empty_after", 4'd0, 4'd0, 1'b1);

      // Stall on empty stream 1; stream 0 must not pop meanwhile.
      tick();
      push(0, 32'd7);
      rd_addr[0] = 4'd1; rd_addr[1] = 4'd0; rd_en = 1'b1;
      #1;
      chk("stall_s1_empty", 256'(stall), 256'(1));
      tick();
      chk("stall_no_valid", 256'(rd_valid), 256'(0));
      chk("stall_data_hold", rd_data[0], {8{32'd2}});
      s_valid[1] = 1'b1; s_data[1] = {LANES{32'd9}};
      #1;
      chk("stall_push_cycle", 256'(stall), 256'(1));
      tick();
      s_valid[1] = 1'b0;
      #1;
      chk("stall_released", 256'(stall), 256'(0));
      tick();
      rd_en = 1'b0;
      chk("unstall_valid", 256'(rd_valid), 256'(1));
      chk("unstall_p0", rd_data[0], {8{32'd9}});
      chk("unstall_p1", rd_data[1], {8{32'd7}});
      probe_stall("s0_single_pop", 4'd0, 4'd0, 1'b1);
      probe_stall("s1_single_pop", 4'd1, 4'd1, 1'b1);

      // Fill stream 0, hold a fifth push, then drain across pointer wrap.
      tick();
      for (int v = 10; v < 14; v++) push(0, N'(v));
      chk("full_ready_low", 256'(s_ready[0]), 256'(0));
      s_valid[0] = 1'b1; s_data[0] = {LANES{32'd14}};
      tick();
      chk("full_held", 256'(s_ready[0]), 256'(0));
      issue(4'd0, 4'd0);
      chk("full_pop_data", rd_data[0], {8{32'd10}});
      chk("full_ready_back", 256'(s_ready[0]), 256'(1));
      tick();
      s_valid[0] = 1'b0;
      chk("refull_ready_low", 256'(s_ready[0]), 256'(0));
      for (int v = 11; v < 15; v++) begin
         issue(4'd0, 4'd0);
         chk($sformatf("wrap_pop%0d_p0", v), rd_data[0], {8{N'(v)}});
         chk($sformatf("wrap_pop%0d_p1", v), rd_data[1], {8{N'(v)}});
      end
      probe_stall("wrap_empty", 4'd0, 4'd1, 1'b1);

      // Same-cycle write and read of address 3, lane 0.
      tick();
      wr_addr = 4'd3; wr_lane_en = 8'hFF; wr_data = {LANES{32'h55555555}};
      tick();
      wr_lane_en = 8'h01; wr_data = {LANES{32'h00000011}};
      issue(4'd3, 4'd3);
      wr_lane_en = '0;
`ifdef VREG_BYPASS_EN
      chk("bypass_p0", rd_data[0], {{7{32'h55555555}}, 32'h00000011});
      chk("bypass_p1", rd_data[1], {{7{32'h55555555}}, 32'h00000011});
`else
      chk("readfirst_p0", rd_data[0], {8{32'h55555555}});
      chk("readfirst_p1", rd_data[1], {8{32'h55555555}});
`endif
      issue(4'd3, 4'd3);
      chk("after_write_p0", rd_data[0], {{7{32'h55555555}}, 32'h00000011});

      // Reset mid-operation with a loaded stream and valid output.
      push(0, 32'd20);
      push(0, 32'd21);
      push(0, 32'd22);
      issue(4'd5, 4'd5);
      chk("pre_rst_valid", 256'(rd_valid), 256'(1));
      rstn = 1'b0; rd_en = 1'b1; rd_addr[0] = 4'd5; rd_addr[1] = 4'd5;
      #1;
      chk("async_rst_valid", 256'(rd_valid), 256'(0));
      chk("async_rst_data", rd_data[0], '0);
      chk("async_rst_ready", 256'(s_ready), 256'(2'b11));
      tick();
      chk("rst_rd_en_ignored", 256'(rd_valid), 256'(0));
      rd_en = 1'b0;
      rstn = 1'b1;
      #1;
      chk("post_rst_ready", 256'(s_ready), 256'(2'b11));
      probe_stall("post_rst_s0_empty", 4'd0, 4'd0, 1'b1);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/vreg_stream_file.md
VREG_STREAM_FILE -- requirements
Module: vreg_stream_file

Interface
REQ-001 SHALL have parameter WIDTH_ADDR, default 4, register address width; 2^WIDTH_ADDR entries.
REQ-002 SHALL have parameter LANES, default 8, vector lanes per entry.
REQ-003 SHALL have parameter N, default 32, bits per lane.
REQ-004 SHALL have parameter NUM_RD, default 2, read ports (1..4).
REQ-005 SHALL have parameter NUM_STREAMS, default 2, stream-mapped addresses 0..NUM_STREAMS-1 (1..4, < 2^WIDTH_ADDR).
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, entries per stream FIFO (power of 2, >= 2).
REQ-007 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-008 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have port rd_en  input  1  read issue request.
REQ-010 SHALL have port rd_addr  input  NUM_RD x WIDTH_ADDR  read address per port.
REQ-011 SHALL have port rd_data  output  NUM_RD x LANES x N  registered read data per port.
REQ-012 SHALL have port rd_valid  output  1  rd_data updated this cycle.
REQ-013 SHALL have port stall  output  1  issue blocked, referenced stream empty.
REQ-014 SHALL have port wr_lane_en  input  LANES  per-lane write enable.
REQ-015 SHALL have port wr_addr  input  WIDTH_ADDR  write address.
REQ-016 SHALL have port wr_data  input  LANES x N  write data.
REQ-017 SHALL have ports s_valid / s_ready  input / output  NUM_STREAMS  per-stream push handshake.
REQ-018 SHALL have port s_data  input  NUM_STREAMS x LANES x N  per-stream push data.

Function
REQ-019 SHALL hold register storage for addresses >= NUM_STREAMS; addresses < NUM_STREAMS read from stream FIFO k = address.
REQ-020 SHALL write lane i of entry wr_addr on a rising edge when wr_lane_en[i]=1; writes to stream addresses are dropped.
REQ-021 SHALL drive stall = rd_en AND (some port addresses stream k AND FIFO k empty), combinationally.
REQ-022 SHALL accept an issue when rd_en=1 and stall=0; rd_data loads next edge, rd_valid=1 for exactly that one cycle (latency 1).
REQ-023 SHALL pop each stream referenced by any port exactly once per accepted issue; all ports naming that stream get the same head entry.
REQ-024 SHALL treat issue as atomic: while stall=1, no stream pops, rd_data holds, rd_valid=0.
REQ-025 SHALL hold rd_data at its last value whenever rd_valid=0.
REQ-026 SHALL drive s_ready[k] = NOT full(k), with no dependence on same-cycle pop; push occurs on s_valid[k] AND s_ready[k].
REQ-027 SHALL, on push into an empty FIFO, make the entry poppable from the next cycle only (no fall-through); same-cycle push and pop on a non-empty, non-full FIFO keeps occupancy.
REQ-028 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH, with full/empty distinguished by one extra pointer bit.
REQ-029 SHALL return, on read of an address written in the same cycle, per-lane behaviour per REQ-033/034.

Reset
REQ-030 SHALL, on rstn=0, asynchronously clear rd_valid=0, rd_data=0, all FIFO pointers (empty), so s_ready=all ones once rstn=1.
REQ-031 SHALL NOT reset register storage contents.
REQ-032 SHALL discard FIFO contents on reset mid-operation; rd_en during reset is ignored.

Configuration
REQ-033 SHALL, with macro VREG_BYPASS_EN defined, return wr_data lane i to a port reading wr_addr in the issuing cycle when wr_lane_en[i]=1 (write-first).
REQ-034 SHALL, without VREG_BYPASS_EN, return pre-write contents in that case (read-first); new data visible from next issue.

Verification
REQ-035 SHALL cover: write addr 5 lanes all 0xA5A5A5A5, issue rd_addr={5,5} next cycle -> rd_valid=1 one cycle later, both ports 0xA5A5A5A5 all lanes.
REQ-036 SHALL cover: push stream 0 values 1,2; issue rd_addr={0,0} twice -> port0=port1=1 then 2; FIFO empty after.
REQ-037 SHALL cover: stream 1 empty, rd_en=1 rd_addr={1,0}, stream 0 holds 7 -> stall=1, stream 0 not popped; push 9 to stream 1 -> next cycle issue accepted, rd_data {9,7}.
REQ-038 SHALL cover: push 4 entries to stream 0 -> s_ready[0]=0; fifth push held; one pop -> s_ready[0]=1 next cycle; pops return in order across pointer wrap.
REQ-039 SHALL cover: same-cycle write addr 3 lane0 = 0x11 and issue read addr 3 -> 0x11 with VREG_BYPASS_EN, old value without.
REQ-040 SHALL cover: rstn=0 with 3 entries in stream 0 and rd_valid=1 -> rd_valid=0, rd_data=0, stream 0 empty, s_ready all ones.
